// File: rtl/des_pkg.sv
// Shared constants and state encoding for the DES SPI command sequencer.
package des_pkg;

  localparam logic [7:0] OP_LOAD_KEY = 8'h01;
  localparam logic [7:0] OP_ENCRYPT  = 8'h02;
  localparam logic [7:0] OP_DECRYPT  = 8'h03;
  localparam logic [7:0] OP_STATUS   = 8'h04;

  localparam logic [7:0] STATUS_TAG  = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_PAY,
    S_START,
    S_BUSY
  } seq_state_t;

endpackage

// File: rtl/des_busy_timer.sv
// Watchdog counter for the BUSY wait on the DES core.
module des_busy_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic sclk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/des_spi_sequencer.sv
// Two-frame SPI command decoder driving a DES core.
module des_spi_sequencer
  import des_pkg::*;
#(
  parameter int WORD_W  = 64,
  parameter int OP_W    = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              frame_vld,
  input  logic [WORD_W-1:0] rx_word,
  output logic [WORD_W-1:0] tx_word,
  output logic [WORD_W-1:0] des_key,
  output logic [WORD_W-1:0] des_din,
  output logic              des_decrypt,
  output logic              des_start,
  input  logic              des_done,
  input  logic [WORD_W-1:0] des_dout,
  output logic              busy,
  output logic              err
);

  seq_state_t state_q, state_d;

  logic [OP_W-1:0]   op_q, op_d, op_hdr;
  logic [WORD_W-1:0] tx_d, key_d, din_d, status_w;
  logic              dec_d;
  logic              kl_q, kl_d;
  logic              eop_q, eop_d;
  logic              eovr_q, eovr_d;
  logic              enk_q, enk_d;
  logic              eto_q, eto_d;
  logic              tmr_load, tmr_en, tmr_exp;

  assign op_hdr    = rx_word[WORD_W-1 -: OP_W];
  assign busy      = (state_q == S_START) || (state_q == S_BUSY);
  assign des_start = (state_q == S_START);

  assign status_w = {STATUS_TAG, {(WORD_W-13){1'b0}},
                     kl_q, busy, eto_q, enk_q, eop_q | eovr_q};

  des_busy_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .sclk   (sclk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tx_d     = tx_word;
    key_d    = des_key;
    din_d    = des_din;
    dec_d    = des_decrypt;
    kl_d     = kl_q;
    eop_d    = eop_q;
    eovr_d   = eovr_q;
    enk_d    = enk_q;
    eto_d    = eto_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_vld) begin
          op_d = op_hdr;
          unique case (1'b1)
            (op_hdr == OP_W'(OP_STATUS)): begin
              tx_d   = status_w;
              eop_d  = 1'b0;
              eovr_d = 1'b0;
              enk_d  = 1'b0;
              eto_d  = 1'b0;
            end
            (op_hdr == OP_W'(OP_LOAD_KEY)),
            (op_hdr == OP_W'(OP_ENCRYPT)),
            (op_hdr == OP_W'(OP_DECRYPT)): begin
              state_d = S_WAIT_PAY;
            end
            default: eop_d = 1'b1;
          endcase
        end
      end
      S_WAIT_PAY: begin
        if (frame_vld) begin
          state_d = S_IDLE;
          if (op_q == OP_W'(OP_LOAD_KEY)) begin
            key_d = rx_word;
            kl_d  = 1'b1;
          end else if (kl_q) begin
            din_d   = rx_word;
            dec_d   = (op_q == OP_W'(OP_DECRYPT));
            state_d = S_START;
          end else begin
            enk_d = 1'b1;
          end
        end
      end
      S_START: begin
        tmr_load = 1'b1;
        state_d  = S_BUSY;
      end
      S_BUSY: begin
        // done takes priority over a coincident timeout
        if (des_done) begin
          tx_d    = des_dout;
          state_d = S_IDLE;
        end else if (tmr_exp) begin
          eto_d   = 1'b1;
          tx_d    = '0;
          state_d = S_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && frame_vld) begin
      eovr_d = 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      tx_word     <= '0;
      des_key     <= '0;
      des_din     <= '0;
      des_decrypt <= 1'b0;
      kl_q        <= 1'b0;
      eop_q       <= 1'b0;
      eovr_q      <= 1'b0;
      enk_q       <= 1'b0;
      eto_q       <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      tx_word     <= tx_d;
      des_key     <= key_d;
      des_din     <= din_d;
      des_decrypt <= dec_d;
      kl_q        <= kl_d;
      eop_q       <= eop_d;
      eovr_q      <= eovr_d;
      enk_q       <= enk_d;
      eto_q       <= eto_d;
      err         <= eop_d | eovr_d | enk_d | eto_d;
    end
  end

endmodule
